mem_req_arbiter: RTL
====================

Name: mem_req_arbiter

Overview:
- Sits directly upstream of the PSRAM memory controller.
- Accepts memory requests from two clients: the CPU (phase-0 domain) and the VIC video fetch (video domain).
- Serialises those requests onto the controller's CE/write/bank/address/data interface and captures read data when the controller signals data-ready.
- Returns each result to its requester over a four-phase req/ack handshake that is safe across clock domains. VIC has fixed priority.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each incoming req line; legal range 2..3.
- TIMEOUT_CYCLES, 1023: clkRAM cycles to wait for controller completion before aborting; 10-bit counter.
- ERR_DATA, 8'hFF: read data returned on timeout.

Ports:
- clkRAM  in  1  memory clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low.
- cpu_req  in  1  CPU request level; held high until cpu_ack rises.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_bank  in  6  bank select; stable while cpu_req is high.
- cpu_addr  in  16  address; stable while cpu_req is high.
- cpu_wdata  in  8  write data; stable while cpu_req is high.
- cpu_ack  out  1  completion acknowledge (four-phase).
- cpu_rdata  out  8  read data; valid while cpu_ack is high.
- cpu_err  out  1  high with cpu_ack when the access timed out.
- vic_req, vic_we, vic_bank, vic_addr, vic_wdata, vic_ack, vic_rdata, vic_err: identical set for the VIC client.
- mem_ce  out  1  controller chip enable; one-cycle pulse per access.
- mem_write  out  1  controller write flag.
- mem_bank  out  6  controller bank.
- mem_addr  out  16  controller address.
- mem_wdata  out  8  controller write data.
- mem_busy  in  1  controller busy.
- mem_data_ready  in  1  controller completion strobe, level or pulse.
- mem_rdata  in  8  controller read data, valid while mem_data_ready is high.
- dbg_state  out  3  current FSM state encoding.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0, except the rdata outputs, which also go to 0.
  - FSM goes to IDLE; synchronisers and timeout counter clear.
  - Any access in flight is abandoned. mem_ce is already low; no ack is generated.
- Request synchronisers: each req passes through SYNC_STAGES flops. Data fields are sampled only after the synchronised req is seen high, so they need no synchroniser.
- FSM states: IDLE(0), ISSUE(1), WAIT_BUSY(2), WAIT_DONE(3), RESPOND(4), RELEASE(5).
- IDLE:
  - If sync vic_req=1 and vic_ack=0, grant VIC.
  - Otherwise, if sync cpu_req=1 and cpu_ack=0, grant CPU.
  - On a grant, latch the client's we/bank/addr/wdata into the mem_* registers and go to ISSUE.
  - If both clients are pending in the same cycle, VIC wins; CPU is served on the next IDLE pass.
- ISSUE:
  - If mem_busy=1, stay in ISSUE with mem_ce=0.
  - Otherwise assert mem_ce=1 for exactly one cycle, clear the timeout counter, and go to WAIT_BUSY.
- WAIT_BUSY:
  - Go to WAIT_DONE when mem_busy=1 or mem_data_ready=1 (covers a controller that completes without showing busy).
  - The timeout counter runs in this state.
- WAIT_DONE:
  - Writes complete when mem_busy falls to 0.
  - Reads complete on the first cycle with mem_data_ready=1; mem_rdata is captured into the granted client's rdata register.
  - On completion, go to RESPOND.
- Timeout: if the counter reaches TIMEOUT_CYCLES in WAIT_BUSY or WAIT_DONE, go to RESPOND with err=1 and rdata=ERR_DATA.
- RESPOND:
  - Set the granted client's ack=1 and err to the timeout flag; go to RELEASE.
  - rdata is updated only for reads; writes leave rdata unchanged.
- RELEASE:
  - Hold ack until that client's synchronised req is 0, then clear ack and err and return to IDLE.
  - The other client is not served while in RELEASE. This is accepted latency; the VIC fetch window covers it.
- Latency: a read with an idle controller reaches ack at SYNC_STAGES + 3 + controller latency clkRAM cycles from the req rising edge.
- mem_* address/data/write registers hold their value between accesses. mem_ce is never high outside ISSUE.
- A client dropping req before ack is a protocol violation. The arbiter still completes the access, raises ack, and falls straight through RELEASE.

Test Plan:
1. CPU write: bank 0, addr 49152 (0xC000), data 20 → one mem_ce pulse with mem_write=1, mem_addr=0xC000, mem_wdata=20; cpu_ack rises after mem_busy falls, cpu_err=0; cpu_ack drops two to three cycles after cpu_req drops.
2. CPU read-back of 0xC000, controller returns 20 → cpu_rdata=20 while cpu_ack=1; vic_ack stays 0 throughout.
3. Simultaneous vic_req (read 0x0400) and cpu_req (write 0xD020=5) → VIC access issued first; CPU mem_ce issued only after vic_req is released; exactly two mem_ce pulses total.
4. mem_busy held high at ISSUE for 50 cycles → mem_ce stays 0 for those cycles, then pulses exactly once.
5. Controller never asserts mem_data_ready on a read → cpu_ack rises TIMEOUT_CYCLES cycles after the mem_ce pulse, with cpu_err=1 and cpu_rdata=0xFF.
6. reset driven low in WAIT_DONE → all acks, mem_ce and dbg_state go to 0 immediately; after reset is released, a held cpu_req is re-served from IDLE.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Two-client request arbiter in front of the PSRAM controller.
// VIC has fixed priority; results return over four-phase req/ack.
module mem_req_arbiter #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter logic [7:0]  ERR_DATA       = 8'hFF
) (
    input  logic        clkRAM,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [5:0]  cpu_bank,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_err,
    input  logic        vic_req,
    input  logic        vic_we,
    input  logic [5:0]  vic_bank,
    input  logic [15:0] vic_addr,
    input  logic [7:0]  vic_wdata,
    output logic        vic_ack,
    output logic [7:0]  vic_rdata,
    output logic        vic_err,
    output logic        mem_ce,
    output logic        mem_write,
    output logic [5:0]  mem_bank,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_busy,
    input  logic        mem_data_ready,
    input  logic [7:0]  mem_rdata,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESPOND   = 3'd4,
        S_RELEASE   = 3'd5
    } state_t;

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] cpu_sync_q;
    logic [SYNC_STAGES-1:0] vic_sync_q;
    logic                   cpu_req_s;
    logic                   vic_req_s;

    state_t      state_q,     state_d;
    logic        gnt_vic_q,   gnt_vic_d;
    logic [9:0]  cnt_q,       cnt_d;
    logic        to_q,        to_d;
    logic        rd_hit_q,    rd_hit_d;
    logic        mem_write_q, mem_write_d;
    logic [5:0]  mem_bank_q,  mem_bank_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        cpu_ack_q,   cpu_ack_d;
    logic        cpu_err_q,   cpu_err_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic        vic_ack_q,   vic_ack_d;
    logic        vic_err_q,   vic_err_d;
    logic [7:0]  vic_rdata_q, vic_rdata_d;

    logic        mem_ce_c;
    logic        rd_load;
    logic [7:0]  rd_val;
    logic        timed_out;

    // Request level synchronisers; data fields are qualified by these
    always_ff @(posedge clkRAM or negedge reset) begin
        if (!reset) begin
            cpu_sync_q <= '0;
            vic_sync_q <= '0;
        end else begin
            cpu_sync_q <= {cpu_sync_q[SYNC_STAGES-2:0], cpu_req};
            vic_sync_q <= {vic_sync_q[SYNC_STAGES-2:0], vic_req};
        end
    end

    assign cpu_req_s = cpu_sync_q[SYNC_STAGES-1];
    assign vic_req_s = vic_sync_q[SYNC_STAGES-1];
    assign timed_out = (cnt_q >= TO_LAST);

    // State, access and response registers
    always_ff @(posedge clkRAM or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            gnt_vic_q   <= 1'b0;
            cnt_q       <= '0;
            to_q        <= 1'b0;
            rd_hit_q    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_bank_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vic_ack_q   <= 1'b0;
            vic_err_q   <= 1'b0;
            vic_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_vic_q   <= gnt_vic_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            rd_hit_q    <= rd_hit_d;
            mem_write_q <= mem_write_d;
            mem_bank_q  <= mem_bank_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            vic_ack_q   <= vic_ack_d;
            vic_err_q   <= vic_err_d;
            vic_rdata_q <= vic_rdata_d;
        end
    end

    // Next-state, grant, timeout and response logic
    always_comb begin
        state_d     = state_q;
        gnt_vic_d   = gnt_vic_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        rd_hit_d    = rd_hit_q;
        mem_write_d = mem_write_q;
        mem_bank_d  = mem_bank_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = cpu_ack_q;
        cpu_err_d   = cpu_err_q;
        cpu_rdata_d = cpu_rdata_q;
        vic_ack_d   = vic_ack_q;
        vic_err_d   = vic_err_q;
        vic_rdata_d = vic_rdata_q;
        mem_ce_c    = 1'b0;
        rd_load     = 1'b0;
        rd_val      = mem_rdata;

        case (state_q)
            S_IDLE: begin
                if (vic_req_s && !vic_ack_q) begin
                    gnt_vic_d   = 1'b1;
                    mem_write_d = vic_we;
                    mem_bank_d  = vic_bank;
                    mem_addr_d  = vic_addr;
                    mem_wdata_d = vic_wdata;
                    state_d     = S_ISSUE;
                end else if (cpu_req_s && !cpu_ack_q) begin
                    gnt_vic_d   = 1'b0;
                    mem_write_d = cpu_we;
                    mem_bank_d  = cpu_bank;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mem_busy) begin
                    mem_ce_c = 1'b1;
                    cnt_d    = '0;
                    to_d     = 1'b0;
                    rd_hit_d = 1'b0;
                    state_d  = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                cnt_d = cnt_q + 10'd1;
                // A short read pulse here must not be lost
                if (mem_data_ready && !mem_write_q) begin
                    rd_load  = 1'b1;
                    rd_hit_d = 1'b1;
                end
                if (mem_busy || mem_data_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (timed_out) begin
                    to_d    = 1'b1;
                    rd_load = !mem_write_q;
                    rd_val  = ERR_DATA;
                    state_d = S_RESPOND;
                end
            end
            S_WAIT_DONE: begin
                cnt_d = cnt_q + 10'd1;
                if (mem_write_q ? !mem_busy : rd_hit_q) begin
                    state_d = S_RESPOND;
                end else if (!mem_write_q && mem_data_ready) begin
                    rd_load = 1'b1;
                    state_d = S_RESPOND;
                end else if (timed_out) begin
                    to_d    = 1'b1;
                    rd_load = !mem_write_q;
                    rd_val  = ERR_DATA;
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (gnt_vic_q) begin
                    vic_ack_d = 1'b1;
                    vic_err_d = to_q;
                end else begin
                    cpu_ack_d = 1'b1;
                    cpu_err_d = to_q;
                end
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (gnt_vic_q && !vic_req_s) begin
                    vic_ack_d = 1'b0;
                    vic_err_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (!gnt_vic_q && !cpu_req_s) begin
                    cpu_ack_d = 1'b0;
                    cpu_err_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rd_load) begin
            if (gnt_vic_q) vic_rdata_d = rd_val;
            else           cpu_rdata_d = rd_val;
        end
    end

    assign mem_ce    = mem_ce_c;
    assign mem_write = mem_write_q;
    assign mem_bank  = mem_bank_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vic_ack   = vic_ack_q;
    assign vic_err   = vic_err_q;
    assign vic_rdata = vic_rdata_q;
    assign dbg_state = state_q;

endmodule
